// File: rtl/imm_encoder.sv
// Streaming RV32I instruction assembler: range-checks and packs an immediate per opcode format,
// then queues the word in a 2-entry FIFO tagged with an auto-incrementing byte address.
module imm_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       ERRCNT_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [4:0]          opcode_i,
    input  logic [4:0]          rd_i,
    input  logic [4:0]          rs1_i,
    input  logic [4:0]          rs2_i,
    input  logic [2:0]          funct3_i,
    input  logic [6:0]          funct7_i,
    input  logic [31:0]         imm_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [31:0]         instr_o,
    output logic [ADDR_W-1:0]   instr_addr_o,
    output logic                err_o,
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    localparam logic [4:0] opc_load   = 5'b00000;
    localparam logic [4:0] opc_op_imm = 5'b00100;
    localparam logic [4:0] opc_auipc  = 5'b00101;
    localparam logic [4:0] opc_store  = 5'b01000;
    localparam logic [4:0] opc_op     = 5'b01100;
    localparam logic [4:0] opc_lui    = 5'b01101;
    localparam logic [4:0] opc_branch = 5'b11000;
    localparam logic [4:0] opc_jalr   = 5'b11001;
    localparam logic [4:0] opc_jal    = 5'b11011;

    // ------------------------------------------------------------------
    // Encode stage (combinational, registered by the FIFO write)
    // ------------------------------------------------------------------
    logic [6:0]  opc_full;
    logic        u_ok;
    logic        i_ok;
    logic        j_ok;
    logic        b_ok;
    logic        sh_ok;
    logic        is_shift;
    logic [31:0] enc_word;
    logic        enc_legal;

    assign opc_full = {opcode_i, 2'b11};

    // Each range test asks whether the upper bits are a pure sign extension.
    assign u_ok     = ~|imm_i[11:0];
    assign i_ok     = (&imm_i[31:11]) | (~|imm_i[31:11]);
    assign j_ok     = ((&imm_i[31:20]) | (~|imm_i[31:20])) & ~imm_i[0];
    assign b_ok     = ((&imm_i[31:12]) | (~|imm_i[31:12])) & ~imm_i[0];
    assign sh_ok    = ~|imm_i[31:5];
    assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        unique case (opcode_i)
            opc_lui, opc_auipc: begin
                enc_word  = {imm_i[31:12], rd_i, opc_full};
                enc_legal = u_ok;
            end
            opc_jal: begin
                enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc_full};
                enc_legal = j_ok;
            end
            opc_jalr, opc_load: begin
                enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opc_full};
                enc_legal = i_ok;
            end
            opc_op_imm: begin
                if (is_shift) begin
                    enc_word  = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opc_full};
                    enc_legal = sh_ok;
                end else begin
                    enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opc_full};
                    enc_legal = i_ok;
                end
            end
            opc_branch: begin
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opc_full};
                enc_legal = b_ok;
            end
            opc_store: begin
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opc_full};
                enc_legal = i_ok;
            end
            opc_op: begin
                enc_word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opc_full};
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO, address counter and error bookkeeping
    // ------------------------------------------------------------------
    logic [31:0]         mem_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                err_q;
    logic [ERRCNT_W-1:0] err_cnt_q;
    logic                accept;
    logic                push;
    logic                pop;

    assign req_ready_o   = (count_q != 2'd2);
    assign instr_valid_o = (count_q != 2'd0);
    assign accept        = req_valid_i & req_ready_o;
    assign push          = accept & enc_legal;
    assign pop           = instr_valid_o & instr_ready_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= enc_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                addr_q   <= addr_q + ADDR_W'(4);
            end
            count_q <= count_d;
            err_q   <= accept & ~enc_legal;
            if (accept && !enc_legal && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
            end
        end
    end

    assign instr_o      = instr_valid_o ? mem_q[rd_ptr_q] : 32'h0;
    assign instr_addr_o = addr_q;
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: a queue-based reference model checked every cycle,
// plus literal expectations from hand-assembled RV32I words.
module tb_imm_encoder;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;

    imm_encoder #(
        .ADDR_W   (32),
        .BASE_ADDR(32'h0),
        .ERRCNT_W (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .opcode_i     (opcode_i),
        .rd_i         (rd_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .imm_i        (imm_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_addr_o (instr_addr_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: signed range tests and bit-field arithmetic on 32-bit values.
    function automatic void menc(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, output logic [31:0] w, output bit ok);
        bit [31:0] u, xrd, xrs1, xrs2, xf3, xf7, low;
        int s;
        u = imm; s = imm; xrd = rd; xrs1 = rs1; xrs2 = rs2; xf3 = f3; xf7 = f7;
        low = ({27'd0, opc} << 2) | 32'd3;
        w = 32'h0; ok = 0;
        case (opc)
            5'b01101, 5'b00101: begin
                w = (u & 32'hFFFFF000) | (xrd << 7) | low;
                ok = ((u & 32'hFFF) == 0);
            end
            5'b11011: begin
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                    (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (xrd << 7) | low;
                ok = (s >= -1048576) && (s <= 1048574) && ((u & 1) == 0);
            end
            5'b11001, 5'b00000, 5'b00100: begin
                if (opc == 5'b00100 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w = (xf7 << 25) | ((u & 31) << 20) | (xrs1 << 15) | (xf3 << 12) |
                        (xrd << 7) | low;
                    ok = (s >= 0) && (s <= 31);
                end else begin
                    w = ((u & 32'hFFF) << 20) | (xrs1 << 15) | (xf3 << 12) | (xrd << 7) | low;
                    ok = (s >= -2048) && (s <= 2047);
                end
            end
            5'b11000: begin
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (xrs2 << 20) |
                    (xrs1 << 15) | (xf3 << 12) | (((u >> 1) & 15) << 8) |
                    (((u >> 11) & 1) << 7) | low;
                ok = (s >= -4096) && (s <= 4094) && ((u & 1) == 0);
            end
            5'b01000: begin
                w = (((u >> 5) & 127) << 25) | (xrs2 << 20) | (xrs1 << 15) | (xf3 << 12) |
                    ((u & 31) << 7) | low;
                ok = (s >= -2048) && (s <= 2047);
            end
            5'b01100: begin
                w = (xf7 << 25) | (xrs2 << 20) | (xrs1 << 15) | (xf3 << 12) | (xrd << 7) | low;
                ok = 1;
            end
            default: ok = 0;
        endcase
    endfunction

    // Model state
    logic [31:0] mq[$];
    logic [31:0] m_addr;
    bit          m_err;
    int          m_cnt;
    bit          live = 0;
    bit          m_rdy, m_pop, m_acc, m_ok;
    logic [31:0] m_w;

    initial begin
        forever begin
            @(posedge clk_i);
            if (rst_i) begin
                mq.delete();
                m_addr = 32'h0;
                m_err  = 0;
                m_cnt  = 0;
                live   = 1;
            end else if (live) begin
                m_rdy = (mq.size() < 2);
                m_pop = (mq.size() > 0) && instr_ready_i;
                m_acc = req_valid_i && m_rdy;
                menc(opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, m_w, m_ok);
                if (m_pop) begin
                    void'(mq.pop_front());
                    m_addr = m_addr + 32'd4;
                end
                if (m_acc && m_ok) mq.push_back(m_w);
                m_err = m_acc && !m_ok;
                if (m_acc && !m_ok && m_cnt < 255) m_cnt++;
            end
        end
    end

    // Per-cycle compare against the model, plus a log of consumed words.
    logic [31:0] log_w[$];
    logic [31:0] log_a[$];
    bit          logging = 0;
    logic [31:0] mhead;

    initial begin
        forever begin
            @(negedge clk_i);
            if (live) begin
                chk("valid", instr_valid_o, mq.size() != 0);
                chk("req_ready", req_ready_o, mq.size() < 2);
                chk("addr", instr_addr_o, m_addr);
                chk("err", err_o, m_err);
                chk("err_cnt", err_cnt_o, m_cnt);
                if (mq.size() != 0) begin
                    mhead = mq[0];
                    chk("instr", instr_o, mhead);
                end
                if (logging && instr_valid_o && instr_ready_i) begin
                    log_w.push_back(instr_o);
                    log_a.push_back(instr_addr_o);
                end
            end
        end
    end

    // Drive one request from posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n;
        bit got;
        opcode_i = opc; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        req_valid_i = 1'b1;
        got = 0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk_i);
            got = req_ready_o;
            @(posedge clk_i);
            n++;
        end
        #1 req_valid_i = 1'b0;
        chk("send_timeout", got, 1'b1);
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic out_is(input string name, input logic [31:0] w, input logic [31:0] a);
        chk({name, "_valid"}, instr_valid_o, 1'b1);
        chk({name, "_word"}, instr_o, w);
        chk({name, "_addr"}, instr_addr_o, a);
    endtask

    task automatic err_is(input string name, input int cnt);
        chk({name, "_err"}, err_o, 1'b1);
        chk({name, "_novalid"}, instr_valid_o, 1'b0);
        chk({name, "_cnt"}, err_cnt_o, cnt);
    endtask

    // Boundary table: opcode, funct3, imm, legality
    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic [31:0] imm;
        bit          ok;
    } bvec_t;

    bvec_t bt[$] = '{
        '{5'b11011, 3'd0, 32'h000FFFFE, 1}, '{5'b11011, 3'd0, 32'h00100000, 0},
        '{5'b11011, 3'd0, 32'hFFF00000, 1}, '{5'b11011, 3'd0, 32'hFFEFFFFE, 0},
        '{5'b11001, 3'd0, 32'h000007FF, 1}, '{5'b11001, 3'd0, 32'h00000800, 0},
        '{5'b00000, 3'd2, 32'hFFFFF800, 1}, '{5'b00000, 3'd2, 32'hFFFFF7FF, 0},
        '{5'b11000, 3'd1, 32'h00000FFE, 1}, '{5'b11000, 3'd1, 32'hFFFFF000, 1},
        '{5'b11000, 3'd1, 32'h00001000, 0}, '{5'b01000, 3'd2, 32'h000007FF, 1},
        '{5'b01000, 3'd2, 32'hFFFFF7FF, 0}, '{5'b00100, 3'd1, 32'h00000000, 1},
        '{5'b00100, 3'd1, 32'hFFFFFFFF, 0}, '{5'b01100, 3'd0, 32'hDEADBEEF, 1},
        '{5'b11111, 3'd0, 32'h00000000, 0}, '{5'b00101, 3'd0, 32'hFFFFF000, 1}
    };

    logic [31:0] pw;
    bit          pok;
    int          ecount;

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; instr_ready_i = 1'b1;
        opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        funct3_i = '0; funct7_i = '0; imm_i = '0;

        // Pin the reference model itself
        menc(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, pw, pok);
        chk("model_addi", {pw, 31'd0, pok}, {32'hFFF00093, 32'd1});
        menc(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, pw, pok);
        chk("model_lui", {pw, 31'd0, pok}, {32'h123452B7, 32'd1});
        menc(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008, pw, pok);
        chk("model_jal", {pw, 31'd0, pok}, {32'h008000EF, 32'd1});
        menc(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, pw, pok);
        chk("model_beq", {pw, 31'd0, pok}, {32'hFE208EE3, 32'd1});
        menc(5'b00100, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd31, pw, pok);
        chk("model_srai", {pw, 31'd0, pok}, {32'h41F1D193, 32'd1});
        menc(5'b00100, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd32, pw, pok);
        chk("model_srai_bad", pok, 1'b0);

        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_cnt", err_cnt_o, 8'd0);
        chk("rst_addr", instr_addr_o, 32'h0);
        chk("rst_ready", req_ready_o, 1'b1);

        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        out_is("addi", 32'hFFF00093, 32'd0);
        send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        out_is("lui", 32'h123452B7, 32'd4);
        send(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008);
        out_is("jal", 32'h008000EF, 32'd8);
        send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        err_is("lui_bad", 1);
        send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
        out_is("beq", 32'hFE208EE3, 32'd12);
        send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000003);
        err_is("beq_odd", 2);
        send(5'b00100, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd31);
        out_is("srai", 32'h41F1D193, 32'd16);
        send(5'b00100, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd32);
        err_is("srai_bad", 3);

        ecount = 3;
        foreach (bt[i]) begin
            send(bt[i].opc, 5'd7, 5'd9, 5'd11, bt[i].f3, 7'h00, bt[i].imm);
            chk($sformatf("bound%0d_err", i), err_o, !bt[i].ok);
            if (!bt[i].ok) ecount++;
        end
        chk("bound_cnt", err_cnt_o, ecount);

        // Saturation of the error counter
        pulse_reset();
        for (int k = 0; k < 260; k++) send(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        chk("sat_cnt", err_cnt_o, 8'hFF);

        // Backpressure: two words fill the FIFO, third waits
        pulse_reset();
        instr_ready_i = 1'b0;
        logging = 1;
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        chk("full_ready", req_ready_o, 1'b0);
        req_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        out_is("held", 32'hFFF00093, 32'd0);
        instr_ready_i = 1'b1;
        send(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008);
        repeat (4) @(posedge clk_i);
        #1 logging = 0;
        chk("log_len", log_w.size(), 3);
        if (log_w.size() == 3) begin
            chk("log0", {log_w[0], log_a[0]}, {32'hFFF00093, 32'd0});
            chk("log1", {log_w[1], log_a[1]}, {32'h123452B7, 32'd4});
            chk("log2", {log_w[2], log_a[2]}, {32'h008000EF, 32'd8});
        end

        // Reset with a full FIFO and a nonzero error count
        instr_ready_i = 1'b0;
        send(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        chk("pre_rst_cnt", err_cnt_o, 8'd1);
        chk("pre_rst_full", req_ready_o, 1'b0);
        pulse_reset();
        chk("mid_rst_valid", instr_valid_o, 1'b0);
        chk("mid_rst_cnt", err_cnt_o, 8'd0);
        chk("mid_rst_addr", instr_addr_o, 32'h0);
        chk("mid_rst_ready", req_ready_o, 1'b1);
        instr_ready_i = 1'b1;
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        out_is("post_rst", 32'hFFF00093, 32'd0);

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
